// File: rtl/mmio_out_port.sv
// Memory-mapped output port: stores to PORT_ADDR queue into a FIFO drained over valid/ready.
// Optional macro MMIO_OUT_TIMESTAMP_EN adds a per-entry 16-bit cycle timestamp on out_ts.
module mmio_out_port #(
    parameter logic [7:0] PORT_ADDR   = 8'hFF,
    parameter logic [7:0] STATUS_ADDR = 8'hFE,
    parameter int         DEPTH       = 4,
    parameter int         DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_wr,
    input  logic              d_rd,
    input  logic [7:0]        d_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] mmio_rdata,
    output logic              mmio_hit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
`ifdef MMIO_OUT_TIMESTAMP_EN
    output logic [15:0]       out_ts,
`endif
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head, tail, head_n;
    logic [CW-1:0]     count, count_n;
    logic              full, empty;
    logic              push, pop, push_ok, clr, drop;
    logic              head_is_new;
    logic [DATA_W-1:0] out_data_n;
    logic [15:0]       status;

`ifdef MMIO_OUT_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_mem [DEPTH];
    logic [15:0] out_ts_n;
`endif

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign push    = d_wr && (d_addr == PORT_ADDR);
    assign pop     = out_valid && out_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign clr     = d_wr && (d_addr == STATUS_ADDR) && w_data[0];

    assign mmio_hit = (d_wr || d_rd) &&
                      ((d_addr == PORT_ADDR) || (d_addr == STATUS_ADDR));

    assign status     = {overflow, full, empty, 5'b0, 8'(count)};
    assign mmio_rdata = (d_rd && d_addr == STATUS_ADDR) ? DATA_W'(status) : '0;

    // Next head/count and the word that becomes the registered head output
    always_comb begin
        head_n      = pop ? head + PW'(1) : head;
        count_n     = count + CW'(push_ok) - CW'(pop);
        head_is_new = push_ok && ((count - CW'(pop)) == '0);
        out_data_n  = '0;
        if (count_n != '0) begin
            out_data_n = head_is_new ? w_data : mem[head_n];
        end
    end

    // Pointer, count, flag and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            head      <= head_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            out_data  <= out_data_n;
            if (push_ok) tail <= tail + PW'(1);
            if (drop) overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
        end
    end

    // FIFO storage write; contents are not reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= w_data;
    end

`ifdef MMIO_OUT_TIMESTAMP_EN
    // Timestamp selection mirrors the data path
    always_comb begin
        out_ts_n = '0;
        if (count_n != '0) begin
            out_ts_n = head_is_new ? ts_cnt : ts_mem[head_n];
        end
    end

    // Free-running cycle counter and timestamp output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt <= '0;
            out_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            out_ts <= out_ts_n;
        end
    end

    // Timestamp storage write
    always_ff @(posedge clk) begin
        if (push_ok) ts_mem[tail] <= ts_cnt;
    end
`endif

endmodule

// File: tb/tb_mmio_out_port.sv
// Directed self-checking bench for mmio_out_port.
// Build with MMIO_OUT_TIMESTAMP_EN to also exercise out_ts.
module tb_mmio_out_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_wr, d_rd, out_ready;
    logic [7:0]  d_addr;
    logic [15:0] w_data;
    logic [15:0] mmio_rdata, out_data;
    logic        mmio_hit, out_valid, overflow;
`ifdef MMIO_OUT_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_out_port dut (
        .clk        (clk),
        .rst        (rst),
        .d_wr       (d_wr),
        .d_rd       (d_rd),
        .d_addr     (d_addr),
        .w_data     (w_data),
        .mmio_rdata (mmio_rdata),
        .mmio_hit   (mmio_hit),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
`ifdef MMIO_OUT_TIMESTAMP_EN
        .out_ts     (out_ts),
`endif
        .overflow   (overflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_wr = 1'b0; d_rd = 1'b0; d_addr = 8'h00; w_data = 16'h0;
    endtask

    task automatic store(input logic [7:0] a, input logic [15:0] v);
        d_wr = 1'b1; d_rd = 1'b0; d_addr = a; w_data = v;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b0; idle();
        cyc();
        d_rd = 1'b1; d_addr = 8'hFE; #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", out_data); end
        total++; if (mmio_rdata !== 16'h2000) begin bad++; $display("FAIL reset_status got=%h want=2000", mmio_rdata); end
        total++; if (mmio_hit !== 1'b1) begin bad++; $display("FAIL status_hit got=%b want=1", mmio_hit); end
        idle();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        d_wr = 1'b1; d_addr = 8'hFF; w_data = 16'h000D; #1;
        total++; if (mmio_hit !== 1'b1) begin bad++; $display("FAIL port_hit got=%b want=1", mmio_hit); end
        cyc();
        idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 16'h000D) begin bad++; $display("FAIL single_data got=%h want=000d", out_data); end
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] exp_seq [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) store(8'hFF, 16'(i));
        d_rd = 1'b1; d_addr = 8'hFE; #1;
        total++; if (mmio_rdata !== 16'hC004) begin bad++; $display("FAIL fill_status got=%h want=c004", mmio_rdata); end
        total++; if (out_data !== 16'd1) begin bad++; $display("FAIL fill_head_stable got=%h want=0001", out_data); end
        idle();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1; #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                bad++; $display("FAIL fill_drain[%0d] got=%b/%h want=1/%h", i, out_valid, out_data, exp_seq[i]);
            end
            cyc();
            out_ready = 1'b0;
            cyc();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b want=0", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_clear();
        d_wr = 1'b1; d_addr = 8'hFE; w_data = 16'h0001;
        cyc();
        idle();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%b want=0", overflow); end
        d_wr = 1'b1; d_rd = 1'b1; d_addr = 8'h10; w_data = 16'h00AA; #1;
        total++; if (mmio_hit !== 1'b0) begin bad++; $display("FAIL other_hit got=%b want=0", mmio_hit); end
        total++; if (mmio_rdata !== 16'h0) begin bad++; $display("FAIL other_rdata got=%h want=0000", mmio_rdata); end
        cyc();
        idle();
        d_rd = 1'b1; d_addr = 8'hFE; #1;
        total++; if (mmio_rdata !== 16'h2000 || out_valid !== 1'b0) begin
            bad++; $display("FAIL other_unchanged got=%h/%b want=2000/0", mmio_rdata, out_valid);
        end
        idle();
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_seq [4] = '{16'd2, 16'd3, 16'd4, 16'd9};
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) store(8'hFF, 16'(i));
        out_ready = 1'b1;
        store(8'hFF, 16'd9);
        d_rd = 1'b1; d_addr = 8'hFE; #1;
        total++; if (mmio_rdata !== 16'h4004) begin bad++; $display("FAIL pp_status got=%h want=4004", mmio_rdata); end
        idle();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                bad++; $display("FAIL pp_drain[%0d] got=%b/%h want=1/%h", i, out_valid, out_data, exp_seq[i]);
            end
            cyc();
        end
        total++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL pp_end got=%b/%b want=0/0", out_valid, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        store(8'hFF, 16'h0055);
        store(8'hFF, 16'h0066);
        #2 rst = 1'b0; #1;
        total++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            bad++; $display("FAIL mid_reset got=%b/%h want=0/0000", out_valid, out_data);
        end
        cyc();
        rst = 1'b1;
        cyc();
        store(8'hFF, 16'h0077);
        total++; if (out_data !== 16'h0077) begin bad++; $display("FAIL post_reset got=%h want=0077", out_data); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

`ifdef MMIO_OUT_TIMESTAMP_EN
    task automatic test_timestamp();
        rst = 1'b0; idle(); out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 6 || e == 10) begin d_wr = 1'b1; d_addr = 8'hFF; w_data = 16'(e); end
            cyc();
            idle();
        end
        total++; if (out_ts !== 16'd5) begin bad++; $display("FAIL ts_first got=%0d want=5", out_ts); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (out_ts !== 16'd9) begin bad++; $display("FAIL ts_second got=%0d want=9", out_ts); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_clear();
        test_full_push_pop();
        test_reset_midstream();
`ifdef MMIO_OUT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
